// File: rtl/mont_pkg.sv
// mont_pkg: shared definitions for the Montgomery exponentiation sequencer.
//   state_t       : sequencer state encoding
//   idx_width()   : width of a bit-count field able to hold 0..n inclusive
package mont_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR_ISSUE,
    S_SQR_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_OUT_ISSUE,
    S_OUT_WAIT,
    S_FINISH
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer computing
// base^exp mod m by driving a single external Montgomery multiplier.
// Operands arrive in Montgomery form; a final multiply-by-1 converts back.
//   clk, rst            : clock, asynchronous active-high reset
//   start_p             : start pulse, accepted only while idle
//   base_m, one_m       : base*R mod m and R mod m
//   exp, e_size         : exponent and number of its low bits to process
//   m, m_size           : modulus and its bit length
//   mul_enable_p        : launches one multiplication (mul_a*mul_b)
//   mul_a, mul_b        : multiplier operands, held until mul_done_p
//   mul_m, mul_m_size   : captured modulus and length for the multiplier
//   mul_y, mul_done_p   : multiplier result and completion pulse
//   busy, done_p        : run in progress / single-cycle completion
//   result              : final result in normal form
//   mul_count           : multiplications issued in current/last run
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned NBITS = 2048,
  parameter int unsigned EBITS = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_p,
  input  logic [NBITS-1:0]         base_m,
  input  logic [NBITS-1:0]         one_m,
  input  logic [EBITS-1:0]         exp,
  input  logic [$clog2(EBITS):0]   e_size,
  input  logic [NBITS-1:0]         m,
  input  logic [$clog2(NBITS):0]   m_size,
  output logic                     mul_enable_p,
  output logic [NBITS-1:0]         mul_a,
  output logic [NBITS-1:0]         mul_b,
  output logic [NBITS-1:0]         mul_m,
  output logic [$clog2(NBITS):0]   mul_m_size,
  input  logic [NBITS-1:0]         mul_y,
  input  logic                     mul_done_p,
  output logic                     busy,
  output logic [NBITS-1:0]         result,
  output logic                     done_p,
  output logic [EBITS+1:0]         mul_count
);

  localparam int unsigned ESW = idx_width(EBITS);
  localparam int unsigned IW  = $clog2(EBITS);
  localparam int unsigned CW  = EBITS + 2;
  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  state_t                 r_state;
  logic [NBITS-1:0]       r_base;
  logic [EBITS-1:0]       r_exp;
  logic [IW-1:0]          r_idx;
  logic [NBITS-1:0]       r_mul_a;
  logic [NBITS-1:0]       r_mul_b;
  logic [NBITS-1:0]       r_mul_m;
  logic [$clog2(NBITS):0] r_mul_m_size;
  logic                   r_enable;
  logic                   r_busy;
  logic                   r_done;
  logic [NBITS-1:0]       r_result;
  logic [CW-1:0]          r_count;

  logic                   w_bit;
  logic                   w_last;

  assign w_bit  = r_exp[r_idx];
  assign w_last = (r_idx == '0);

  // Operands, enable pulse and count are loaded on the edge that enters an
  // ISSUE state, so the pulse coincides with that state. The accumulator
  // lives in r_mul_a: every product is either the next A operand or result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_exp        <= '0;
      r_idx        <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_m      <= '0;
      r_mul_m_size <= '0;
      r_enable     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_count      <= '0;
    end else begin
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_p) begin
            r_base       <= base_m;
            r_exp        <= exp;
            r_mul_m      <= m;
            r_mul_m_size <= m_size;
            r_idx        <= IW'(e_size - ESW'(1));
            r_busy       <= 1'b1;
            r_mul_a      <= one_m;
            r_enable     <= 1'b1;
            r_count      <= CW'(1);
            if (e_size != '0) begin
              r_mul_b <= one_m;
              r_state <= S_SQR_ISSUE;
            end else begin
              r_mul_b <= ONE;
              r_state <= S_OUT_ISSUE;
            end
          end
        end
        S_SQR_ISSUE: r_state <= S_SQR_WAIT;
        S_SQR_WAIT: begin
          if (mul_done_p) begin
            r_mul_a  <= mul_y;
            r_enable <= 1'b1;
            r_count  <= r_count + CW'(1);
            if (w_bit) begin
              r_mul_b <= r_base;
              r_state <= S_MUL_ISSUE;
            end else if (w_last) begin
              r_mul_b <= ONE;
              r_state <= S_OUT_ISSUE;
            end else begin
              r_idx   <= r_idx - IW'(1);
              r_mul_b <= mul_y;
              r_state <= S_SQR_ISSUE;
            end
          end
        end
        S_MUL_ISSUE: r_state <= S_MUL_WAIT;
        S_MUL_WAIT: begin
          if (mul_done_p) begin
            r_mul_a  <= mul_y;
            r_enable <= 1'b1;
            r_count  <= r_count + CW'(1);
            if (w_last) begin
              r_mul_b <= ONE;
              r_state <= S_OUT_ISSUE;
            end else begin
              r_idx   <= r_idx - IW'(1);
              r_mul_b <= mul_y;
              r_state <= S_SQR_ISSUE;
            end
          end
        end
        S_OUT_ISSUE: r_state <= S_OUT_WAIT;
        S_OUT_WAIT: begin
          if (mul_done_p) begin
            r_result <= mul_y;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mul_enable_p = r_enable;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign mul_m        = r_mul_m;
  assign mul_m_size   = r_mul_m_size;
  assign busy         = r_busy;
  assign result       = r_result;
  assign done_p       = r_done;
  assign mul_count    = r_count;

endmodule
